// File: rtl/seq_mul_arb.sv
// seq_mul_arb: arbitrated two-stage multiplier that feeds an in-order response FIFO.
// Define SEQ_MUL_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module seq_mul_arb #(
  parameter int NREQ  = 3,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*W-1:0]        i_opA,
  input  logic [NREQ*W-1:0]        i_opB,
  output logic [NREQ-1:0]          o_gnt,
  output logic                     o_rspValid,
  output logic [$clog2(NREQ)-1:0]  o_rspId,
  output logic [W-1:0]             o_rspData,
  input  logic                     i_rspReady
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic           r_s1Valid;
  logic [W-1:0]   r_s1A;
  logic [W-1:0]   r_s1B;
  logic [IDW-1:0] r_s1Id;

  logic [W-1:0]   r_memData [DEPTH];
  logic [IDW-1:0] r_memId   [DEPTH];
  logic [PW-1:0]  r_wrPtr;
  logic [PW-1:0]  r_rdPtr;
  logic [CW-1:0]  r_count;

  logic           w_canGrant;
  logic           w_found;
  logic           w_push;
  logic           w_pop;
  logic [IDW-1:0] w_gntIdx;
  logic [IDW-1:0] w_start;
  logic [W-1:0]   w_opA;
  logic [W-1:0]   w_opB;
  logic [W-1:0]   w_prod;
  logic [CW:0]    w_occupancy;

`ifdef SEQ_MUL_ARB_RR_EN
  logic [IDW-1:0] r_rrPtr;
  assign w_start = r_rrPtr;
`else
  assign w_start = '0;
`endif

  // The FIFO slot written at the end of the second cycle acts as the stage-2 register,
  // so only stage 1 is counted as in flight; a same-cycle pop is deliberately not credited.
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_s1Valid};
  assign w_canGrant  = w_occupancy < (CW+1)'(DEPTH);

  always_comb begin
    int j;
    j        = 0;
    o_gnt    = '0;
    w_gntIdx = '0;
    w_found  = 1'b0;
    if (w_canGrant && !reset) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (int'(w_start) + k) % NREQ;
        if (!w_found && i_req[j]) begin
          o_gnt[j] = 1'b1;
          w_gntIdx = IDW'(j);
          w_found  = 1'b1;
        end
      end
    end
  end

  assign w_opA  = i_opA[w_gntIdx*W +: W];
  assign w_opB  = i_opB[w_gntIdx*W +: W];
  assign w_prod = r_s1A * r_s1B;

  assign w_push     = r_s1Valid;
  assign o_rspValid = (r_count != '0);
  assign w_pop      = o_rspValid && i_rspReady;
  assign o_rspId    = r_memId[r_rdPtr];
  assign o_rspData  = r_memData[r_rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
    end else begin
      r_s1Valid <= w_found;
    end
    if (w_found) begin
      r_s1A  <= w_opA;
      r_s1B  <= w_opB;
      r_s1Id <= w_gntIdx;
    end
  end

  // Product is truncated to W bits and lands in the FIFO one cycle after capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_memData[r_wrPtr] <= w_prod;
        r_memId[r_wrPtr]   <= r_s1Id;
        r_wrPtr            <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SEQ_MUL_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rrPtr <= '0;
    end else if (w_found) begin
      r_rrPtr <= (w_gntIdx == IDW'(NREQ-1)) ? '0 : w_gntIdx + IDW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_mul_arb.sv
// tb_seq_mul_arb: directed self-checking bench for seq_mul_arb (default parameters).
// Expectations follow SEQ_MUL_ARB_RR_EN when the macro is defined for the build.
module tb_seq_mul_arb;

  localparam int NREQ  = 3;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] opA;
  logic [NREQ*W-1:0] opB;
  logic [NREQ-1:0]   gnt;
  logic              rspValid;
  logic [1:0]        rspId;
  logic [W-1:0]      rspData;
  logic              rspReady;

  logic [W-1:0] aVal [NREQ];
  logic [W-1:0] bVal [NREQ];
  int nChecks;
  int nPass;

  seq_mul_arb #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (req),
    .i_opA      (opA),
    .i_opB      (opB),
    .o_gnt      (gnt),
    .o_rspValid (rspValid),
    .o_rspId    (rspId),
    .o_rspData  (rspData),
    .i_rspReady (rspReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drives one cycle just after the rising edge, then returns at the falling edge for sampling.
  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] r, input logic rdy);
    @(posedge clk);
    #1;
    reset    = rst;
    req      = r;
    rspReady = rdy;
    for (int i = 0; i < NREQ; i++) begin
      opA[i*W +: W] = aVal[i];
      opB[i*W +: W] = bVal[i];
    end
    #4;
  endtask

  logic [31:0] expGnt;
  logic [31:0] expId;
  logic [31:0] expData [NREQ];

  initial begin
    clk = 1'b0; reset = 1'b1; req = '0; rspReady = 1'b1; opA = '0; opB = '0;
    nChecks = 0; nPass = 0;
    for (int i = 0; i < NREQ; i++) begin aVal[i] = '0; bVal[i] = '0; end

    applyStimulus(1'b1, 3'b111, 1'b1);
    applyStimulus(1'b1, 3'b111, 1'b1);
    checkOutput("resetGnt", 32'(gnt), 32'd0);
    checkOutput("resetValid", 32'(rspValid), 32'd0);

    aVal[0] = 8'd3; bVal[0] = 8'd5;
    applyStimulus(1'b0, 3'b001, 1'b1);
    checkOutput("singleGnt", 32'(gnt), 32'd1);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("singleNotEarly", 32'(rspValid), 32'd0);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("singleValid", 32'(rspValid), 32'd1);
    checkOutput("singleId", 32'(rspId), 32'd0);
    checkOutput("singleData", 32'(rspData), 32'd15);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("singlePopped", 32'(rspValid), 32'd0);

    aVal[2] = 8'd16; bVal[2] = 8'd17;
    applyStimulus(1'b0, 3'b100, 1'b1);
    checkOutput("wrapGnt", 32'(gnt), 32'd4);
    applyStimulus(1'b0, 3'b000, 1'b1);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("wrapId", 32'(rspId), 32'd2);
    checkOutput("wrapData", 32'(rspData), 32'd16);

    // All requesters held: checks grant pattern and in-order responses two cycles behind.
    aVal[0] = 8'd2; bVal[0] = 8'd3; aVal[1] = 8'd4; bVal[1] = 8'd5;
    expData[0] = 32'd6; expData[1] = 32'd20; expData[2] = 32'd16;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, (k < 6) ? 3'b111 : 3'b000, 1'b1);
`ifdef SEQ_MUL_ARB_RR_EN
      expGnt = 32'(1 << (k % 3));
      expId  = 32'((k + 1) % 3);
`else
      expGnt = 32'd1;
      expId  = 32'd0;
`endif
      if (k < 6) checkOutput("allGnt", 32'(gnt), expGnt);
      if (k >= 2) begin
        checkOutput("allId", 32'(rspId), expId);
        checkOutput("allData", 32'(rspData), expData[expId]);
      end
    end
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("allDrained", 32'(rspValid), 32'd0);

    bVal[1] = 8'd3;
    for (int c = 0; c < 4; c++) begin
      aVal[1] = 8'(c + 1);
      applyStimulus(1'b0, 3'b010, 1'b0);
      checkOutput("fullGnt", 32'(gnt), 32'd2);
    end
    applyStimulus(1'b0, 3'b010, 1'b0);
    checkOutput("fullStop", 32'(gnt), 32'd0);
    applyStimulus(1'b0, 3'b010, 1'b0);
    checkOutput("fullStop2", 32'(gnt), 32'd0);
    checkOutput("fullValid", 32'(rspValid), 32'd1);
    checkOutput("fullId", 32'(rspId), 32'd1);
    checkOutput("fullData", 32'(rspData), 32'd3);
    applyStimulus(1'b0, 3'b010, 1'b0);
    checkOutput("fullHold", 32'(rspData), 32'd3);
    aVal[1] = 8'd9;
    applyStimulus(1'b0, 3'b010, 1'b1);
    checkOutput("drainNoCredit", 32'(gnt), 32'd0);
    checkOutput("drain0", 32'(rspData), 32'd3);
    applyStimulus(1'b0, 3'b010, 1'b1);
    checkOutput("drainResume", 32'(gnt), 32'd2);
    checkOutput("drain1", 32'(rspData), 32'd6);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("drain2", 32'(rspData), 32'd9);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("drain3", 32'(rspData), 32'd12);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("drain4", 32'(rspData), 32'd27);
    checkOutput("drain4Id", 32'(rspId), 32'd1);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("drainEmpty", 32'(rspValid), 32'd0);

    // FIFO at 3 with one in flight: a same-cycle pop must not enable a grant.
    aVal[0] = 8'd1; bVal[0] = 8'd1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 3'b001, 1'b0);
      checkOutput("edgeGnt", 32'(gnt), 32'd1);
    end
    applyStimulus(1'b0, 3'b001, 1'b1);
    checkOutput("edgeNoGnt", 32'(gnt), 32'd0);
    checkOutput("edgeData", 32'(rspData), 32'd1);
    applyStimulus(1'b0, 3'b001, 1'b1);
    checkOutput("edgeNextGnt", 32'(gnt), 32'd1);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("edgeDrained", 32'(rspValid), 32'd0);

    aVal[0] = 8'd7; bVal[0] = 8'd9;
    applyStimulus(1'b0, 3'b001, 1'b1);
    checkOutput("midGnt", 32'(gnt), 32'd1);
    applyStimulus(1'b1, 3'b001, 1'b1);
    checkOutput("midResetGnt", 32'(gnt), 32'd0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 3'b000, 1'b1);
      checkOutput("midDiscard", 32'(rspValid), 32'd0);
    end
    applyStimulus(1'b0, 3'b011, 1'b1);
    checkOutput("ptrCleared", 32'(gnt), 32'd1);
    applyStimulus(1'b0, 3'b000, 1'b1);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("postValid", 32'(rspValid), 32'd1);
    checkOutput("postId", 32'(rspId), 32'd0);
    checkOutput("postData", 32'(rspData), 32'd63);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
